// File: rtl/scmemarb_pkg.sv
// Shared constants and state encoding for the data-memory arbiter.
package scmemarb_pkg;

    localparam int DMEM_AW = 5;
    localparam int DMEM_DW = 32;

    typedef enum logic {
        ST_CLR = 1'b0,
        ST_RUN = 1'b1
    } state_e;

endpackage

// File: rtl/scmemarb_scrrarb2.sv
// Two-way round-robin picker: on a tie the port that was not granted last wins.
module scrrarb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | last);
        gnt[1] = req[1] & (~req[0] | ~last);
    end

endmodule

// File: rtl/scmemarb.sv
// Shares the 32-word data memory between the CPU (port 0) and the loader (port 1),
// with an optional zero sweep after reset and address checking in front of the memory.
//
// Handshake: a port raises req and holds we/addr/wdata stable until it sees ack=1
// at a posedge; ack is combinational in the grant cycle, err qualifies ack, and
// rdata is meaningful only while ack=1, err=0 and we=0.
module scmemarb
    import scmemarb_pkg::*;
#(
    parameter int AW           = DMEM_AW,
    parameter int DW           = DMEM_DW,
    parameter bit CLR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [31:0]   p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic          p0_err,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [31:0]   p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic          p1_err,
    output logic [DW-1:0] p1_rdata,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          busy
);

    state_e        state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic          last_q, last_d;

    logic [1:0]    gnt;
    logic          win;
    logic [31:0]   win_addr;
    logic          win_we;
    logic [DW-1:0] win_wdata;
    logic          win_ok;

    scrrarb2 u_arb (
        .req  ({p1_req, p0_req}),
        .last (last_q),
        .gnt  (gnt)
    );

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        last_d    = last_q;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_din   = '0;
        busy      = 1'b0;
        p0_ack    = 1'b0;
        p0_err    = 1'b0;
        p0_rdata  = '0;
        p1_ack    = 1'b0;
        p1_err    = 1'b0;
        p1_rdata  = '0;

        win       = gnt[1];
        win_addr  = win ? p1_addr  : p0_addr;
        win_we    = win ? p1_we    : p0_we;
        win_wdata = win ? p1_wdata : p0_wdata;
        // Word-aligned and inside the 2^AW-word window; anything else never reaches memory.
        win_ok    = (win_addr[1:0] == 2'b00) && ((win_addr >> (AW + 2)) == 32'd0);

        if (rst) begin
            busy = 1'b1;
        end else if (state_q == ST_CLR) begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {{(30-AW){1'b0}}, clr_idx_q, 2'b00};
            clr_idx_d = clr_idx_q + AW'(1);
            if (clr_idx_q == {AW{1'b1}}) begin
                state_d = ST_RUN;
            end
        end else if (|gnt) begin
            // Rejected accesses still consume the grant so the other port is not starved.
            last_d = win;
            if (win_ok) begin
                mem_we   = win_we;
                mem_addr = win_addr;
                mem_din  = win_wdata;
            end
            if (win) begin
                p1_ack   = 1'b1;
                p1_err   = ~win_ok;
                p1_rdata = (win_ok && !win_we) ? mem_dout : '0;
            end else begin
                p0_ack   = 1'b1;
                p0_err   = ~win_ok;
                p0_rdata = (win_ok && !win_we) ? mem_dout : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLR_ON_RESET ? ST_CLR : ST_RUN;
            clr_idx_q <= '0;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            last_q    <= last_d;
        end
    end

endmodule

// File: tb/tb_scmemarb.sv
// Directed bench for scmemarb: sweep, single-port access, address errors,
// reset during the sweep, contention ordering and a same-word write race.
module tb_scmemarb;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [31:0]   p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_ack, p0_err, p1_ack, p1_err;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_din, mem_dout;
    logic          busy;

    logic [DW-1:0] mem [0:31];
    logic          pl_en;
    logic [4:0]    pl_idx;
    logic [DW-1:0] pl_data;

    logic [DW-1:0] exp_q[$];
    int            n_assert = 0;
    int            n_fail   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    scmemarb #(.AW(5), .DW(DW), .CLR_ON_RESET(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .p0_req   (p0_req),
        .p0_we    (p0_we),
        .p0_addr  (p0_addr),
        .p0_wdata (p0_wdata),
        .p0_ack   (p0_ack),
        .p0_err   (p0_err),
        .p0_rdata (p0_rdata),
        .p1_req   (p1_req),
        .p1_we    (p1_we),
        .p1_addr  (p1_addr),
        .p1_wdata (p1_wdata),
        .p1_ack   (p1_ack),
        .p1_err   (p1_err),
        .p1_rdata (p1_rdata),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .busy     (busy)
    );

    // Behavioural data memory: asynchronous read, write at posedge.
    assign mem_dout = mem[mem_addr[6:2]];
    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (mem_we) mem[mem_addr[6:2]] <= mem_din;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic req, input logic we, input logic [31:0] addr, input logic [DW-1:0] wd);
        p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wd;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic [31:0] addr, input logic [DW-1:0] wd);
        p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wd;
    endtask

    // ---------------- scoreboard check ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", busy, 1);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_p0_ack", p0_ack, 0);
        chk("rst_p1_ack", p1_ack, 0);
        chk("rst_p0_err", p0_err, 0);
        chk("rst_p1_err", p1_err, 0);
        chk("rst_p0_rdata", p0_rdata, 0);
        chk("rst_p1_rdata", p1_rdata, 0);
    endtask

    task automatic run_sweep();
        for (int i = 0; i < 32; i++) begin
            #1;
            chk("sweep_busy", busy, 1);
            chk("sweep_we", mem_we, 1);
            chk("sweep_addr", mem_addr, 32'(i * 4));
            chk("sweep_din", mem_din, 0);
            chk("sweep_p0_ack", p0_ack, 0);
            chk("sweep_p1_ack", p1_ack, 0);
            tick();
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        set_p0(0, 0, 32'd0, '0);
        set_p1(0, 0, 32'd0, '0);
        pl_en = 1'b1; pl_idx = 5'h14; pl_data = 32'h0000_00A3;
        #1;
        chk_reset_outputs();
        tick();
        pl_en = 1'b0;
        rst   = 1'b0;
        chk("preload", mem[20], 32'h0000_00A3);

        // Sweep with a pending port 0 read of the preloaded word.
        set_p0(1, 0, 32'h50, '0);
        run_sweep();
        #1;
        chk("run_busy", busy, 0);
        chk("first_read_ack", p0_ack, 1);
        chk("first_read_err", p0_err, 0);
        chk("first_read_addr", mem_addr, 32'h50);
        chk("first_read_data", p0_rdata, 32'h0);
        chk("first_read_p1_rdata", p1_rdata, 32'h0);
        tick();
        set_p0(0, 0, 32'd0, '0);
        chk("swept_word", mem[20], 32'h0);

        // Single port: port 1 write then read back.
        set_p1(1, 1, 32'h5C, 32'h0000_0115);
        exp_q.push_back(32'h0000_0115);
        #1;
        chk("p1_wr_ack", p1_ack, 1);
        chk("p1_wr_p0_ack", p0_ack, 0);
        chk("p1_wr_we", mem_we, 1);
        chk("p1_wr_addr", mem_addr, 32'h5C);
        chk("p1_wr_din", mem_din, 32'h0000_0115);
        tick();
        chk("p1_wr_mem", mem[23], 32'h0000_0115);
        set_p1(1, 0, 32'h5C, '0);
        #1;
        chk("p1_rd_ack", p1_ack, 1);
        chk("p1_rd_p0_ack", p0_ack, 0);
        chk("p1_rd_we", mem_we, 0);
        chk("p1_rd_data", p1_rdata, exp_q.pop_front());
        tick();
        set_p1(0, 0, 32'd0, '0);
        #1;
        chk("idle_p0_ack", p0_ack, 0);
        chk("idle_p1_ack", p1_ack, 0);
        chk("idle_we", mem_we, 0);
        chk("idle_addr", mem_addr, 32'h0);

        // Errors: misaligned, then out of range.
        set_p0(1, 1, 32'h52, 32'hDEAD_BEEF);
        #1;
        chk("mis_ack", p0_ack, 1);
        chk("mis_err", p0_err, 1);
        chk("mis_we", mem_we, 0);
        chk("mis_rdata", p0_rdata, 0);
        tick();
        set_p0(1, 1, 32'h80, 32'hCAFE_0001);
        #1;
        chk("oor_ack", p0_ack, 1);
        chk("oor_err", p0_err, 1);
        chk("oor_we", mem_we, 0);
        tick();
        set_p0(0, 0, 32'd0, '0);
        chk("mis_mem_unchanged", mem[20], 32'h0);
        chk("oor_mem_unchanged", mem[0], 32'h0);

        // Errored grants moved the pointer to port 0, so port 1 wins this tie.
        set_p0(1, 0, 32'h50, '0);
        set_p1(1, 0, 32'h5C, '0);
        #1;
        chk("rr_p1_ack", p1_ack, 1);
        chk("rr_p0_wait", p0_ack, 0);
        chk("rr_addr", mem_addr, 32'h5C);
        chk("rr_p1_rdata", p1_rdata, 32'h0000_0115);
        tick();
        set_p1(0, 0, 32'd0, '0);
        #1;
        chk("rr_p0_ack", p0_ack, 1);
        chk("rr_p0_addr", mem_addr, 32'h50);
        tick();
        set_p0(0, 0, 32'd0, '0);

        // Reset, then reset again at sweep cycle 10 with both ports pending.
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        tick();
        rst = 1'b0;
        set_p0(1, 0, 32'h5C, '0);
        set_p1(1, 1, 32'h60, 32'h0000_0033);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("early_sweep_p0_ack", p0_ack, 0);
            chk("early_sweep_addr", mem_addr, 32'(i * 4));
            tick();
        end
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        tick();
        rst = 1'b0;
        run_sweep();

        // Contention right after reset: grants 0,1,0,1.
        #1;
        chk("c1_p0_ack", p0_ack, 1);
        chk("c1_p1_ack", p1_ack, 0);
        chk("c1_addr", mem_addr, 32'h5C);
        chk("c1_we", mem_we, 0);
        chk("c1_rdata", p0_rdata, 32'h0);
        tick();
        set_p0(1, 0, 32'h60, '0);
        #1;
        chk("c2_p1_ack", p1_ack, 1);
        chk("c2_p0_ack", p0_ack, 0);
        chk("c2_addr", mem_addr, 32'h60);
        chk("c2_we", mem_we, 1);
        chk("c2_din", mem_din, 32'h0000_0033);
        exp_q.push_back(32'h0000_0033);
        tick();
        #1;
        chk("c3_p0_ack", p0_ack, 1);
        chk("c3_p1_ack", p1_ack, 0);
        chk("c3_addr", mem_addr, 32'h60);
        chk("c3_rdata", p0_rdata, exp_q.pop_front());
        tick();
        #1;
        chk("c4_p1_ack", p1_ack, 1);
        chk("c4_p0_ack", p0_ack, 0);
        chk("c4_addr", mem_addr, 32'h60);
        tick();
        set_p0(0, 0, 32'd0, '0);
        set_p1(0, 0, 32'd0, '0);

        // Same-word race with last=1: port 0 first, port 1's data survives.
        set_p0(1, 1, 32'h54, 32'h0000_0011);
        set_p1(1, 1, 32'h54, 32'h0000_0022);
        #1;
        chk("race_p0_ack", p0_ack, 1);
        chk("race_p1_wait", p1_ack, 0);
        chk("race_din0", mem_din, 32'h0000_0011);
        tick();
        set_p0(0, 0, 32'd0, '0);
        #1;
        chk("race_p1_ack", p1_ack, 1);
        chk("race_din1", mem_din, 32'h0000_0022);
        exp_q.push_back(32'h0000_0022);
        tick();
        set_p1(0, 0, 32'd0, '0);
        set_p0(1, 0, 32'h54, '0);
        #1;
        chk("race_rd_ack", p0_ack, 1);
        chk("race_rd_data", p0_rdata, exp_q.pop_front());
        chk("race_mem", mem[21], 32'h0000_0022);
        tick();
        set_p0(0, 0, 32'd0, '0);

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/scmemarb.md
Name: scmemarb

Overview:
- Sequences and shares the single-cycle CPU's 32-word data memory between two requesters: port 0 is the CPU load/store path, port 1 is the loader/debug path.
- Optionally zero-sweeps the memory after reset.
- Round-robin arbitrates one word access per cycle.
- Flags misaligned or out-of-range addresses as errors and never lets them reach the memory.
- Sits between the requesters and the data memory; drives its write-enable, address and write-data, and consumes its asynchronous read data.

Parameters:
AW, 5, log2 of memory depth in words (32 words)
DW, 32, data width
CLR_ON_RESET, 1, 1 = zero-sweep all words after reset; 0 = skip the sweep

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
p0_req  in  1  port 0 access request, held until acked
p0_we  in  1  port 0 write (1) / read (0)
p0_addr  in  32  port 0 byte address
p0_wdata  in  DW  port 0 write data
p0_ack  out  1  port 0 access performed this cycle
p0_err  out  1  qualifies p0_ack: access rejected
p0_rdata  out  DW  port 0 read data, valid while p0_ack=1 and p0_we=0
p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_err, p1_rdata  same as port 0, for port 1
mem_we  out  1  memory write enable
mem_addr  out  32  memory byte address, word-aligned
mem_din  out  DW  memory write data
mem_dout  in  DW  memory asynchronous read data
busy  out  1  clear sweep in progress or reset asserted

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Registered state:
  - state: CLR or RUN
  - clr_idx: AW bits
  - last: last-granted port, 1 bit
- All outputs are combinational from the registered state and the inputs.
- Reset (rst=1 at a posedge):
  - state <= CLR if CLR_ON_RESET, else RUN
  - clr_idx <= 0
  - last <= 1, so port 0 wins the first tie
- While rst=1, regardless of state: mem_we=0, all ack=0, all err=0, busy=1, all rdata=0.
- Reset asserted mid-sweep or mid-access aborts it; the sweep restarts from word 0.
- CLR state:
  - mem_we=1, mem_addr={clr_idx,2'b00} zero-extended, mem_din=0, busy=1.
  - clr_idx increments each cycle. On clr_idx=2^AW-1, state <= RUN.
  - The sweep takes exactly 32 cycles.
  - Requests are ignored (ack=0) and stay pending.
- RUN state (busy=0):
  - Winner selection:
    - Only one req high: that port wins.
    - Both high: the port != last wins.
    - Neither high: mem_we=0, mem_addr=0, mem_din=0.
  - Winner's ack=1 in the same cycle, and last <= winner at the posedge.
  - The loser's ack=0 and its request remains pending.
  - Valid address: addr[1:0]==0 and addr[31:AW+2]==0.
    - mem_addr = winner addr; mem_din = winner wdata; mem_we = winner we.
    - Read data: winner rdata = mem_dout.
    - Writes commit at the posedge ending the ack cycle.
  - Invalid address:
    - err=1 with ack=1; mem_we=0; rdata=0.
    - The grant still counts for round-robin.
  - Non-winner rdata=0.
  - A requester that sees ack at a posedge either drops req or presents its next access.
  - Back-to-back: each port gets at most one access per cycle; two continuously requesting ports alternate 0,1,0,1.
- Latency: zero wait states when uncontended. Worst case: 1 extra cycle under contention, or 32 extra cycles after reset.
- Loser's pending access: the arbiter latches nothing, so the requester must hold addr/we/wdata stable while req=1.
- Simultaneous writes from both ports to the same word: serialized in grant order, so the later grant's data survives.

Decomposition:
- Shared package constants: DMEM_AW=5, DMEM_DW=32, and the state encodings ST_CLR=1'b0, ST_RUN=1'b1.
- One natural sub-module, scrrarb2: a 2-way round-robin picker (inputs req[1:0] and last; outputs gnt[1:0]), purely combinational.
- The last-granted pointer and the FSM stay in scmemarb.

Test Plan:
- Sweep: rst pulse for 1 cycle with CLR_ON_RESET=1 and memory preloaded with 0xA3 at word 0x14.
  - busy=1 for exactly 32 cycles; mem_we=1 with mem_addr 0x00..0x7C in order.
  - Afterwards a port 0 read of 0x50 returns 0 with ack in the first RUN cycle.
- Single port: port 1 writes 0x00000115 to 0x5C, then reads 0x5C.
  - ack on each cycle with zero wait states; read returns 0x00000115.
  - p0_ack stays 0 throughout.
- Contention: both ports hold req for 4 cycles, immediately after reset.
  - Grant order is 0,1,0,1; each ack is one cycle.
  - The loser's addresses never appear on mem_addr in the loser's cycle.
- Errors: port 0 writes to 0x52 (misaligned), then to 0x80 (out of range).
  - Each gives ack=1, err=1, mem_we=0; memory contents unchanged.
  - The round-robin pointer advances.
- Reset mid-sweep: rst asserted at sweep cycle 10 while p0_req=1.
  - No ack during the sweep; busy=1 for 32 cycles after rst deasserts.
  - p0 is acked in the first RUN cycle.
- Same-word race: port 0 writes 0x11 to 0x54 and port 1 writes 0x22 to 0x54 in the same cycle, with last=1.
  - Port 0 is granted first, port 1 next; a final read returns 0x22.
